// File: rtl/slot_pkg.sv
// Shared types and constants for the slot score keeper: FSM states, win classes, reel constants.
// Pure declarations; no logic or latency of its own.
package slot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPIN,
    EVAL,
    PAYOUT,
    WAIT_CLR
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'd0;
  localparam logic [1:0] WIN_PAIR  = 2'd1;
  localparam logic [1:0] WIN_THREE = 2'd2;
  localparam logic [1:0] WIN_FOUR  = 2'd3;

  localparam logic [3:0] SEVEN = 4'd7;

  // Clamp an elaboration-time payout amount into the 8-bit payout field.
  function automatic logic [7:0] sat8(input int v);
    logic [7:0] r;
    if (v > 255) begin
      r = 8'd255;
    end else if (v < 0) begin
      r = 8'd0;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/slot_score_keeper_if.sv
// Play-request / reel-result bundle feeding the score keeper, plus its status back to the display stage.
// master drives spin and the reel values; slave is the score keeper.
interface slot_score_keeper_if #(
  parameter int CRED_W = 10
);

  logic              spin;
  logic              result_valid;
  logic [3:0]        randNum1;
  logic [3:0]        randNum2;
  logic [3:0]        randNum3;
  logic [3:0]        randNum4;
  logic [CRED_W-1:0] credits;
  logic [1:0]        win_code;
  logic [7:0]        payout;
  logic              win_pulse;
  logic              insufficient;
  logic              busy;
  logic              seven_jackpot;

  modport master (
    output spin, result_valid, randNum1, randNum2, randNum3, randNum4,
    input  credits, win_code, payout, win_pulse, insufficient, busy, seven_jackpot
  );

  modport slave (
    input  spin, result_valid, randNum1, randNum2, randNum3, randNum4,
    output credits, win_code, payout, win_pulse, insufficient, busy, seven_jackpot
  );

endinterface

// File: rtl/slot_match_classify.sv
// Combinational match classifier: maximum digit multiplicity among four reels mapped to a win class.
// Zero latency; no handshake.
module slot_match_classify
  import slot_pkg::*;
(
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [1:0] win_code
);

  logic e01, e02, e03, e12, e13, e23;
  logic [1:0] c0, c1, c2, c3;

  assign e01 = (d0 == d1);
  assign e02 = (d0 == d2);
  assign e03 = (d0 == d3);
  assign e12 = (d1 == d2);
  assign e13 = (d1 == d3);
  assign e23 = (d2 == d3);

  // Per-digit count of *other* digits that match it; max count + 1 is the multiplicity.
  always_comb begin
    c0 = {1'b0, e01} + {1'b0, e02} + {1'b0, e03};
    c1 = {1'b0, e01} + {1'b0, e12} + {1'b0, e13};
    c2 = {1'b0, e02} + {1'b0, e12} + {1'b0, e23};
    c3 = {1'b0, e03} + {1'b0, e13} + {1'b0, e23};
  end

  always_comb begin
    win_code = WIN_NONE;
    if ((c0 == 2'd3) || (c1 == 2'd3) || (c2 == 2'd3) || (c3 == 2'd3)) begin
      win_code = WIN_FOUR;
    end else if ((c0 == 2'd2) || (c1 == 2'd2) || (c2 == 2'd2) || (c3 == 2'd2)) begin
      win_code = WIN_THREE;
    end else if ((c0 != 2'd0) || (c1 != 2'd0) || (c2 != 2'd0) || (c3 != 2'd0)) begin
      win_code = WIN_PAIR;
    end
  end

endmodule

// File: rtl/slot_score_keeper.sv
// Slot score keeper: debit a bet per spin, latch settled reels, classify, credit a saturating payout.
// Latch-to-credit latency 3 edges; waits in WAIT_CLR until result_valid drops. SLOT_SEVEN_JACKPOT_EN enables the four-7s jackpot.
module slot_score_keeper
  import slot_pkg::*;
#(
  parameter int CRED_W       = 10,
  parameter int INIT_CREDITS = 100,
  parameter int BET          = 1,
  parameter int PAY_PAIR     = 2,
  parameter int PAY_THREE    = 10,
  parameter int PAY_FOUR     = 50
) (
  input  logic              clk,
  input  logic              reset,
  slot_score_keeper_if.slave bus
);

  localparam logic [CRED_W-1:0] INIT_C   = CRED_W'(INIT_CREDITS);
  localparam logic [CRED_W-1:0] BET_C    = CRED_W'(BET);
  localparam logic [CRED_W-1:0] CRED_MAX = '1;
  localparam logic [7:0]        PAY_P    = sat8(PAY_PAIR);
  localparam logic [7:0]        PAY_T    = sat8(PAY_THREE);
  localparam logic [7:0]        PAY_F    = sat8(PAY_FOUR);
  // One spare bit above the wider of the two addends so the overflow is always visible.
  localparam int                SUM_W    = ((CRED_W > 8) ? CRED_W : 8) + 1;

  state_t            state_q, state_d;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic [1:0]        win_code_q, win_code_d;
  logic [7:0]        payout_q, payout_d;
  logic              win_pulse_q, win_pulse_d;
  logic              insufficient_q, insufficient_d;
  logic              seven_q, seven_d;
  logic [3:0][3:0]   dig_q, dig_d;

  logic [1:0]        class_code;
  logic [7:0]        class_pay;
  logic [SUM_W-1:0]  sum;
  logic [CRED_W-1:0] credits_sat;

  slot_match_classify u_classify (
    .d0       (dig_q[0]),
    .d1       (dig_q[1]),
    .d2       (dig_q[2]),
    .d3       (dig_q[3]),
    .win_code (class_code)
  );

  always_comb begin
    class_pay = 8'd0;
    case (class_code)
      WIN_PAIR:  class_pay = PAY_P;
      WIN_THREE: class_pay = PAY_T;
      WIN_FOUR:  class_pay = PAY_F;
      default:   class_pay = 8'd0;
    endcase
  end

`ifdef SLOT_SEVEN_JACKPOT_EN
  localparam logic [7:0] PAY_JACK = sat8(2 * PAY_FOUR);
  logic is_seven;
  assign is_seven = (dig_q[0] == SEVEN) && (dig_q[1] == SEVEN) &&
                    (dig_q[2] == SEVEN) && (dig_q[3] == SEVEN);
`endif

  always_comb begin
    sum         = SUM_W'(credits_q) + SUM_W'(payout_q);
    credits_sat = (sum > SUM_W'(CRED_MAX)) ? CRED_MAX : sum[CRED_W-1:0];
  end

  always_comb begin
    state_d        = state_q;
    credits_d      = credits_q;
    win_code_d     = win_code_q;
    payout_d       = payout_q;
    win_pulse_d    = 1'b0;
    insufficient_d = 1'b0;
    seven_d        = seven_q;
    dig_d          = dig_q;

    case (state_q)
      IDLE: begin
        if (bus.spin) begin
          if (credits_q >= BET_C) begin
            credits_d  = credits_q - BET_C;
            win_code_d = WIN_NONE;
            payout_d   = 8'd0;
            seven_d    = 1'b0;
            state_d    = SPIN;
          end else begin
            insufficient_d = 1'b1;
          end
        end
      end
      SPIN: begin
        if (bus.result_valid) begin
          dig_d   = {bus.randNum4, bus.randNum3, bus.randNum2, bus.randNum1};
          state_d = EVAL;
        end
      end
      EVAL: begin
        win_code_d = class_code;
        payout_d   = class_pay;
`ifdef SLOT_SEVEN_JACKPOT_EN
        if (is_seven) begin
          payout_d = PAY_JACK;
          seven_d  = 1'b1;
        end
`endif
        state_d = PAYOUT;
      end
      PAYOUT: begin
        credits_d   = credits_sat;
        win_pulse_d = (payout_q != 8'd0);
        state_d     = WAIT_CLR;
      end
      WAIT_CLR: begin
        // Hold off until the reels restart so one result is never scored twice.
        if (!bus.result_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      credits_q      <= INIT_C;
      win_code_q     <= WIN_NONE;
      payout_q       <= 8'd0;
      win_pulse_q    <= 1'b0;
      insufficient_q <= 1'b0;
      seven_q        <= 1'b0;
      dig_q          <= '0;
    end else begin
      state_q        <= state_d;
      credits_q      <= credits_d;
      win_code_q     <= win_code_d;
      payout_q       <= payout_d;
      win_pulse_q    <= win_pulse_d;
      insufficient_q <= insufficient_d;
      seven_q        <= seven_d;
      dig_q          <= dig_d;
    end
  end

  assign bus.credits       = credits_q;
  assign bus.win_code      = win_code_q;
  assign bus.payout        = payout_q;
  assign bus.win_pulse     = win_pulse_q;
  assign bus.insufficient  = insufficient_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.seven_jackpot = seven_q;

endmodule

// File: tb/tb_slot_score_keeper.sv
// Directed bench for slot_score_keeper: three instances (default, zero credits, 7-bit saturating) share one stimulus.
// Expected play results are queued at stimulus time and popped when the payout lands.
module tb_slot_score_keeper;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       spin  = 1'b0;
  logic       rv    = 1'b0;
  logic [3:0] r1 = 4'd0, r2 = 4'd0, r3 = 4'd0, r4 = 4'd0;

  int checks     = 0;
  int errors     = 0;
  int pulses_a   = 0;
  int exp_pulses = 0;
  int cred_a     = 100;
  int cred_c     = 120;

  typedef struct {
    int code;
    int pay;
    int ca;
    int cc;
    bit seven;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  slot_score_keeper_if #(.CRED_W(10)) ifa ();
  slot_score_keeper_if #(.CRED_W(10)) ifb ();
  slot_score_keeper_if #(.CRED_W(7))  ifc ();

  assign ifa.spin = spin;  assign ifa.result_valid = rv;
  assign ifa.randNum1 = r1; assign ifa.randNum2 = r2; assign ifa.randNum3 = r3; assign ifa.randNum4 = r4;
  assign ifb.spin = spin;  assign ifb.result_valid = rv;
  assign ifb.randNum1 = r1; assign ifb.randNum2 = r2; assign ifb.randNum3 = r3; assign ifb.randNum4 = r4;
  assign ifc.spin = spin;  assign ifc.result_valid = rv;
  assign ifc.randNum1 = r1; assign ifc.randNum2 = r2; assign ifc.randNum3 = r3; assign ifc.randNum4 = r4;

  slot_score_keeper #(.CRED_W(10), .INIT_CREDITS(100)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  slot_score_keeper #(.CRED_W(10), .INIT_CREDITS(0))   dut_b (.clk(clk), .reset(reset), .bus(ifb));
  slot_score_keeper #(.CRED_W(7),  .INIT_CREDITS(120)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  always @(negedge clk) begin
    if (ifa.win_pulse === 1'b1) pulses_a++;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    cred_a = 100;
    cred_c = 120;
  endtask

  task automatic set_digits(input logic [3:0] a1, input logic [3:0] a2,
                            input logic [3:0] a3, input logic [3:0] a4);
    r1 = a1; r2 = a2; r3 = a3; r4 = a4;
    rv = 1'b1;
  endtask

  // One full play: spin accepted, reels valid, EVAL, PAYOUT, WAIT_CLR, back to IDLE.
  task automatic play(input logic [3:0] a1, input logic [3:0] a2,
                      input logic [3:0] a3, input logic [3:0] a4,
                      input int code, input int pay, input bit seven,
                      input bit rv_early, input bit mid_spin);
    exp_t e;
    int   deb_a;
    int   deb_c;
    deb_a   = cred_a - 1;
    deb_c   = cred_c - 1;
    e.code  = code;
    e.pay   = pay;
    e.seven = seven;
    e.ca    = sat(deb_a + pay, 1023);
    e.cc    = sat(deb_c + pay, 127);
    sb.push_back(e);
    if (pay != 0) exp_pulses++;

    @(negedge clk);
    spin = 1'b1;
    if (rv_early) set_digits(a1, a2, a3, a4);
    @(negedge clk);
    spin = 1'b0;
    chk("debit_a", ifa.credits, deb_a);
    chk("busy_spin", ifa.busy, 1);
    chk("code_cleared", ifa.win_code, 0);
    chk("payout_cleared", ifa.payout, 0);
    chk("seven_cleared", ifa.seven_jackpot, 0);
    chk("debit_c", ifc.credits, deb_c);
    chk("insuf_b", ifb.insufficient, 1);
    chk("busy_b", ifb.busy, 0);
    chk("cred_b", ifb.credits, 0);
    if (mid_spin) begin
      spin = 1'b1;
      @(negedge clk);
      spin = 1'b0;
      chk("mid_spin_cred", ifa.credits, deb_a);
      chk("mid_spin_busy", ifa.busy, 1);
      chk("mid_spin_insuf_b", ifb.insufficient, 1);
    end
    if (!rv_early) set_digits(a1, a2, a3, a4);
    @(negedge clk);
    chk("insuf_b_one_cycle", ifb.insufficient, 0);
    chk("busy_eval", ifa.busy, 1);
    @(negedge clk);
    chk("code_early", ifa.win_code, code);
    chk("cred_before_payout", ifa.credits, deb_a);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("credits_a", ifa.credits, e.ca);
      chk("credits_c", ifc.credits, e.cc);
      chk("win_code", ifa.win_code, e.code);
      chk("payout", ifa.payout, e.pay);
      chk("win_pulse", ifa.win_pulse, (e.pay != 0) ? 1 : 0);
      chk("seven_jackpot", ifa.seven_jackpot, e.seven);
    end
    spin = 1'b1;
    @(negedge clk);
    spin = 1'b0;
    chk("win_pulse_one_cycle", ifa.win_pulse, 0);
    chk("busy_wait_clr", ifa.busy, 1);
    chk("wait_clr_cred", ifa.credits, e.ca);
    rv = 1'b0;
    @(negedge clk);
    chk("busy_idle", ifa.busy, 0);
    chk("code_hold", ifa.win_code, e.code);
    chk("payout_hold", ifa.payout, e.pay);
    chk("cred_hold", ifa.credits, e.ca);
    cred_a = e.ca;
    cred_c = e.cc;
  endtask

  initial begin
    int jp_pay;
    bit jp_seven;
`ifdef SLOT_SEVEN_JACKPOT_EN
    jp_pay   = 100;
    jp_seven = 1'b1;
`else
    jp_pay   = 50;
    jp_seven = 1'b0;
`endif

    #2 reset = 1'b1;
    #1;
    chk("rst_credits_a", ifa.credits, 100);
    chk("rst_win_code", ifa.win_code, 0);
    chk("rst_payout", ifa.payout, 0);
    chk("rst_win_pulse", ifa.win_pulse, 0);
    chk("rst_insufficient", ifa.insufficient, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_seven", ifa.seven_jackpot, 0);
    chk("rst_credits_b", ifb.credits, 0);
    chk("rst_credits_c", ifc.credits, 120);
    @(negedge clk);
    reset = 1'b0;

    play(4'd3, 4'd3, 4'd3, 4'd3, 3, 50, 1'b0, 1'b0, 1'b0);
    chk("four_threes_total", ifa.credits, 149);
    chk("c_saturated_1", ifc.credits, 127);

    do_reset();
    play(4'd1, 4'd2, 4'd3, 4'd4, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("no_match_total", ifa.credits, 99);

    do_reset();
    play(4'd5, 4'd5, 4'd9, 4'd9, 1, 2, 1'b0, 1'b0, 1'b0);
    chk("two_pair_total", ifa.credits, 101);
    play(4'd6, 4'd6, 4'd6, 4'd2, 2, 10, 1'b0, 1'b0, 1'b1);
    chk("three_total", ifa.credits, 110);
    chk("c_saturated_2", ifc.credits, 127);

    do_reset();
    play(4'd8, 4'd8, 4'd8, 4'd8, 3, 50, 1'b0, 1'b0, 1'b1);
    chk("c_saturated_eights", ifc.credits, 127);
    play(4'd9, 4'd5, 4'd5, 4'd9, 1, 2, 1'b0, 1'b0, 1'b0);
    play(4'd0, 4'd15, 4'd15, 4'd15, 2, 10, 1'b0, 1'b0, 1'b0);
    chk("mixed_total", ifa.credits, 159);

    // Reset asserted while the dut sits in EVAL.
    @(negedge clk);
    spin = 1'b1;
    @(negedge clk);
    spin = 1'b0;
    set_digits(4'd12, 4'd12, 4'd12, 4'd12);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_credits_a", ifa.credits, 100);
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_code", ifa.win_code, 0);
    chk("mid_rst_payout", ifa.payout, 0);
    chk("mid_rst_pulse", ifa.win_pulse, 0);
    chk("mid_rst_credits_c", ifc.credits, 120);
    @(negedge clk);
    reset  = 1'b0;
    rv     = 1'b0;
    cred_a = 100;
    cred_c = 120;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_credits", ifa.credits, 100);
    chk("post_rst_busy", ifa.busy, 0);

    play(4'd7, 4'd7, 4'd7, 4'd7, 3, jp_pay, jp_seven, 1'b0, 1'b0);
    chk("seven_total", ifa.credits, 99 + jp_pay);

    chk("pulse_count", pulses_a, exp_pulses);
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
